// File: rtl/nw_fill_controller.sv
// Sequencing FSM for the Needleman-Wunsch score-matrix fill.
// It runs the init counter, then walks every cell (i,j) through
// READ -> WAIT (RD_LAT-1 cycles) -> CALC -> WRITE. It owns the counter
// enables, the score-RAM strobes and the neighbour/write addresses.
module nw_fill_controller #(
  parameter int N      = 128,
  parameter int RD_LAT = 1,
  localparam int IW    = $clog2(N) + 1,
  localparam int AW    = $clog2((N + 1) * (N + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          end_init,
  input  logic          end_filling,
  input  logic [IW-1:0] i,
  input  logic [IW-1:0] j,
  output logic          en_init,
  output logic          en_read,
  output logic          change_index,
  output logic          rd_en,
  output logic [AW-1:0] addr_diag,
  output logic [AW-1:0] addr_up,
  output logic [AW-1:0] addr_left,
  output logic          we,
  output logic [AW-1:0] addr_wr,
  output logic          calc_en,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    CALC  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [AW-1:0] ROW_STRIDE = AW'(N + 1);
  // Last WAIT count value; only reachable when RD_LAT > 1.
  localparam logic [2:0]    WAIT_LAST  = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt;
  logic        no_nbr;
  logic [IW-1:0] i_m1, j_m1;

  // Row-major cell address r*(N+1)+c, unsigned and truncated to AW bits.
  function automatic logic [AW-1:0] cell_addr(input logic [IW-1:0] r,
                                              input logic [IW-1:0] c);
    return AW'(r) * ROW_STRIDE + AW'(c);
  endfunction

  // Row 0 / column 0 cells have no upper-left neighbour to read.
  assign no_nbr = (i == '0) || (j == '0);
  // Decrements wrap at 0; the addresses are then don't-care but stay defined.
  assign i_m1   = i - IW'(1);
  assign j_m1   = j - IW'(1);

  assign addr_diag = cell_addr(i_m1, j_m1);
  assign addr_up   = cell_addr(i_m1, j);
  assign addr_left = cell_addr(i, j_m1);
  assign addr_wr   = cell_addr(i, j);

  // State register, WAIT counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == READ) begin
        wait_cnt <= 3'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      if ((state == IDLE) && start) begin
        err <= 1'b0;
      end else if ((state == READ) && no_nbr) begin
        err <= 1'b1;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = INIT;
      INIT:  if (end_init) state_nxt = READ;
      READ: begin
        if (no_nbr)           state_nxt = DONE;
        else if (RD_LAT == 1) state_nxt = CALC;
        else                  state_nxt = WAIT;
      end
      WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = CALC;
      CALC:  state_nxt = WRITE;
      WRITE: state_nxt = end_filling ? DONE : READ;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded strobes; reset forces IDLE so all strobes drop at once.
  always_comb begin
    en_init      = 1'b0;
    en_read      = 1'b0;
    change_index = 1'b0;
    rd_en        = 1'b0;
    we           = 1'b0;
    calc_en      = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    case (state)
      INIT:  en_init = 1'b1;
      READ: begin
        en_read = 1'b1;
        rd_en   = 1'b1;
      end
      WAIT:  en_read = 1'b1;
      CALC: begin
        en_read = 1'b1;
        calc_en = 1'b1;
      end
      WRITE: begin
        en_read      = 1'b1;
        we           = 1'b1;
        change_index = !end_filling;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nw_fill_controller.sv
// Directed bench for nw_fill_controller: instance A (N=4, RD_LAT=1) and
// instance B (N=4, RD_LAT=3), each with behavioural init/insertion counters.
module tb_nw_fill_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- instance A: N=4, RD_LAT=1 ----------------
  logic       rst_a = 1'b1, start_a = 1'b0, force_ei_a = 1'b0, force_i0_a = 1'b0;
  logic       end_init_a, end_filling_a;
  logic [2:0] ia, ja, ri_a, rj_a, icnt_a;
  logic       en_init_a, en_read_a, change_index_a, rd_en_a, we_a, calc_en_a;
  logic       busy_a, done_a, err_a;
  logic [4:0] addr_diag_a, addr_up_a, addr_left_a, addr_wr_a;

  nw_fill_controller #(.N(4), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .end_init(end_init_a),
    .end_filling(end_filling_a), .i(ia), .j(ja),
    .en_init(en_init_a), .en_read(en_read_a), .change_index(change_index_a),
    .rd_en(rd_en_a), .addr_diag(addr_diag_a), .addr_up(addr_up_a),
    .addr_left(addr_left_a), .we(we_a), .addr_wr(addr_wr_a),
    .calc_en(calc_en_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ri_a <= 3'd1; rj_a <= 3'd1; icnt_a <= 3'd0;
    end else begin
      if (en_init_a) begin
        icnt_a <= icnt_a + 3'd1; ri_a <= 3'd1; rj_a <= 3'd1;
      end else begin
        icnt_a <= 3'd0;
      end
      if (change_index_a) begin
        if (rj_a == 3'd4) begin rj_a <= 3'd1; ri_a <= ri_a + 3'd1; end
        else rj_a <= rj_a + 3'd1;
      end
    end
  end
  assign end_init_a    = force_ei_a | (icnt_a == 3'd4);
  assign end_filling_a = (ri_a == 3'd4) && (rj_a == 3'd4);
  assign ia            = force_i0_a ? 3'd0 : ri_a;
  assign ja            = rj_a;

  logic clr_a = 1'b0;
  int   we_cnt_a, ci_cnt_a, init_cyc_a, rdph_a, done_cnt_a, last_we_a, done_cyc_a;
  int   wr_log_a [16];
  logic [4:0] cap_diag, cap_up, cap_left, cap_wr;

  always @(negedge clk) begin
    if (clr_a) begin
      we_cnt_a = 0; ci_cnt_a = 0; init_cyc_a = 0; rdph_a = 0; done_cnt_a = 0;
      last_we_a = 0; done_cyc_a = 0;
      cap_diag = '0; cap_up = '0; cap_left = '0; cap_wr = '0;
      for (int k = 0; k < 16; k++) wr_log_a[k] = 0;
    end else if (!rst_a) begin
      if (we_a) begin
        if (we_cnt_a < 16) wr_log_a[we_cnt_a] = int'(addr_wr_a);
        we_cnt_a++; last_we_a = cyc;
        if (ia == 3'd2 && ja == 3'd3) cap_wr = addr_wr_a;
      end
      if (change_index_a) ci_cnt_a++;
      if (en_init_a) init_cyc_a++;
      if (en_read_a) rdph_a++;
      if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
      if (rd_en_a && ia == 3'd2 && ja == 3'd3) begin
        cap_diag = addr_diag_a; cap_up = addr_up_a; cap_left = addr_left_a;
      end
    end
  end

  // ---------------- instance B: N=4, RD_LAT=3 ----------------
  logic       rst_b = 1'b1, start_b = 1'b0;
  logic       end_filling_b;
  logic [2:0] ib, jb;
  logic       en_init_b, en_read_b, change_index_b, rd_en_b, we_b, calc_en_b;
  logic       busy_b, done_b, err_b;
  logic [4:0] addr_diag_b, addr_up_b, addr_left_b, addr_wr_b;

  nw_fill_controller #(.N(4), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .end_init(1'b1),
    .end_filling(end_filling_b), .i(ib), .j(jb),
    .en_init(en_init_b), .en_read(en_read_b), .change_index(change_index_b),
    .rd_en(rd_en_b), .addr_diag(addr_diag_b), .addr_up(addr_up_b),
    .addr_left(addr_left_b), .we(we_b), .addr_wr(addr_wr_b),
    .calc_en(calc_en_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ib <= 3'd1; jb <= 3'd1;
    end else if (en_init_b) begin
      ib <= 3'd1; jb <= 3'd1;
    end else if (change_index_b) begin
      if (jb == 3'd4) begin jb <= 3'd1; ib <= ib + 3'd1; end
      else jb <= jb + 3'd1;
    end
  end
  assign end_filling_b = (ib == 3'd4) && (jb == 3'd4);

  logic clr_b = 1'b0;
  int   rd_cnt_b, calc_cnt_b, we_cnt_b, rd0_b, rd1_b, calc0_b;

  always @(negedge clk) begin
    if (clr_b) begin
      rd_cnt_b = 0; calc_cnt_b = 0; we_cnt_b = 0; rd0_b = 0; rd1_b = 0; calc0_b = 0;
    end else if (!rst_b) begin
      if (rd_en_b) begin
        if (rd_cnt_b == 0) rd0_b = cyc;
        if (rd_cnt_b == 1) rd1_b = cyc;
        rd_cnt_b++;
      end
      if (calc_en_b) begin
        if (calc_cnt_b == 0) calc0_b = cyc;
        calc_cnt_b++;
      end
      if (we_b) we_cnt_b++;
    end
  end

  function automatic logic [8:0] outs_a();
    return {en_init_a, en_read_a, change_index_a, rd_en_a, we_a, calc_en_a, busy_a, done_a, err_a};
  endfunction
  function automatic logic [8:0] outs_b();
    return {en_init_b, en_read_b, change_index_b, rd_en_b, we_b, calc_en_b, busy_b, done_b, err_b};
  endfunction

  initial begin
    logic found;

    // Reset state
    @(negedge clk);
    check("reset_outs_a", 32'(outs_a()), 32'd0);
    check("reset_addr_wr_a", 32'(addr_wr_a), 32'd6);
    check("reset_addr_up_a", 32'(addr_up_a), 32'd1);
    check("reset_outs_b", 32'(outs_b()), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b1; clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0; clr_b = 1'b0;

    // Full run on A, with a stray start mid-run
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_busy_a", 32'(busy_a), 32'd1);
    check("start_en_init_a", 32'(en_init_a), 32'd1);
    repeat (20) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_a) begin found = 1'b1; break; end
    end
    check("run_done_seen_a", 32'(found), 32'd1);
    @(negedge clk);
    check("busy_after_done_a", 32'(busy_a), 32'd0);
    check("we_count_a", 32'(we_cnt_a), 32'd16);
    check("change_index_count_a", 32'(ci_cnt_a), 32'd15);
    check("init_cycles_a", 32'(init_cyc_a), 32'd5);
    check("fill_cycles_a", 32'(rdph_a), 32'd48);
    check("done_count_a", 32'(done_cnt_a), 32'd1);
    check("we_to_done_a", 32'(done_cyc_a - last_we_a), 32'd1);
    for (int r = 1; r <= 4; r++)
      for (int c = 1; c <= 4; c++)
        check($sformatf("addr_wr_seq_%0d_%0d", r, c),
              32'(wr_log_a[(r - 1) * 4 + (c - 1)]), 32'(r * 5 + c));
    check("addr_diag_2_3", 32'(cap_diag), 32'd7);
    check("addr_up_2_3", 32'(cap_up), 32'd8);
    check("addr_left_2_3", 32'(cap_left), 32'd12);
    check("addr_wr_2_3", 32'(cap_wr), 32'd13);

    // Error path on A, with end_init already high at INIT entry
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0; force_ei_a = 1'b1; force_i0_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a) begin found = 1'b1; break; end
    end
    check("err_done_seen_a", 32'(found), 32'd1);
    @(negedge clk);
    check("init_one_cycle_a", 32'(init_cyc_a), 32'd1);
    check("err_no_we_a", 32'(we_cnt_a), 32'd0);
    check("err_done_count_a", 32'(done_cnt_a), 32'd1);
    check("err_sticky_a", 32'(err_a), 32'd1);
    force_i0_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("err_cleared_a", 32'(err_a), 32'd0);
    check("restart_en_init_a", 32'(en_init_a), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;

    // Latency and reset-during-WAIT on B
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rd_en_b && jb == 3'd2) begin found = 1'b1; break; end
    end
    check("second_read_seen_b", 32'(found), 32'd1);
    @(negedge clk);
    check("in_wait_b", 32'({en_read_b, rd_en_b, calc_en_b, we_b}), 32'b1000);
    check("rd_to_calc_b", 32'(calc0_b - rd0_b), 32'd3);
    check("cycles_per_cell_b", 32'(rd1_b - rd0_b), 32'd5);
    #2 rst_b = 1'b1;
    #1 check("async_reset_outs_b", 32'(outs_b()), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("idle_after_reset_b", 32'(outs_b()), 32'd0);
    check("we_count_b", 32'(we_cnt_b), 32'd1);
    check("rd_count_b", 32'(rd_cnt_b), 32'd2);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("restart_init_b", 32'({en_init_b, busy_b}), 32'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
